// File: rtl/dmem_pipe.sv
// dmem_pipe: data memory for the CPU load/store path.
// Byte/half/word/dword accesses over a valid/ready request port. Load results
// are sign- or zero-extended and returned after RD_LAT cycles on a
// backpressurable response port. Misaligned, out-of-range and illegal-size
// accesses are flagged with rsp_err and never modify memory.
// Optional build macro DMEM_RESET_CLEAR_EN: after reset, a CLEAR -> IDLE FSM
// zeroes the memory one word per cycle before requests are accepted.
module dmem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int WIX_W = ADDR_W - OFF_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Number of bytes touched by an access of the given size code.
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    // Mask covering the low bits of an access of the given size.
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
        int nbits;
        nbits = 8 * size_bytes(size);
        if (nbits >= DATA_W)
            return '1;
        return (DATA_W'(1) << nbits) - DATA_W'(1);
    endfunction

    // Misaligned, out-of-range or dword-on-32-bit accesses are rejected.
    function automatic logic access_err(input logic [1:0]       size,
                                        input logic [OFF_W-1:0] off_in,
                                        input logic [WIX_W-1:0] widx);
        logic e;
        e = 1'b0;
        if ((size == 2'b11) && (DATA_W == 32))
            e = 1'b1;
        if ((int'(off_in) % size_bytes(size)) != 0)
            e = 1'b1;
        if (widx >= WIX_W'(DEPTH))
            e = 1'b1;
        return e;
    endfunction

    // Sign- or zero-extend a right-aligned load value.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] top;
        logic              sgn;
        mask = size_mask(size);
        top  = raw >> (8 * size_bytes(size) - 1);
        sgn  = top[0] & ~uns & ~(&mask);
        return (raw & mask) | (~mask & {DATA_W{sgn}});
    endfunction

    // Replace only the addressed byte lanes of a memory word.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [1:0]        size,
                                                      input logic [OFF_W-1:0]  off_in);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] sh;
        mask = size_mask(size) << {off_in, 3'b000};
        sh   = wdata << {off_in, 3'b000};
        return (old & ~mask) | (sh & mask);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [OFF_W-1:0]  off;
    logic [WIX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              err;
    logic              st_we;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;
    logic              stall;
    logic              ready_ok;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;

    logic              vld_p   [RD_LAT];
    logic [DATA_W-1:0] rdata_p [RD_LAT];
    logic              err_p   [RD_LAT];

    assign off      = req_addr[OFF_W-1:0];
    assign word_idx = req_addr[ADDR_W-1:OFF_W];
    assign idx      = word_idx[IDX_W-1:0];

    assign stall     = vld_p[RD_LAT-1] && !rsp_ready;
    assign req_ready = ready_ok && !stall;
    assign accept    = req_valid && req_ready;
    assign err       = access_err(req_size, off, word_idx);
    assign st_we     = accept && req_we && !err;

    // Decode the accepted request into store data and the extended load value.
    always_comb begin
        st_data = store_merge(mem[idx], req_wdata, req_size, off);
        ld_data = '0;
        if (accept && !req_we && !err)
            ld_data = load_extend(mem[idx] >> {off, 3'b000}, req_size, req_unsigned);
    end

`ifdef DMEM_RESET_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, state_nxt;

    // Clear-sweep state and word pointer; reset restarts the sweep at word 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // Next state: stay in CLEAR until the last word has been written.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        ready_ok  = 1'b1;
        case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                ready_ok = 1'b0;
                if (clr_idx == IDX_W'(DEPTH - 1))
                    state_nxt = IDLE;
            end
            default: ;
        endcase
    end
`else
    assign clr_we   = 1'b0;
    assign clr_idx  = '0;
    assign ready_ok = 1'b1;
`endif

    // Single write port: clear sweep or committed store.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_idx] <= '0;
        else if (st_we)
            mem[idx] <= st_data;
    end

    // Response pipeline: stage 0 captures the accept, later stages shift; all hold on stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i]   <= 1'b0;
                rdata_p[i] <= '0;
                err_p[i]   <= 1'b0;
            end
        end else if (!stall) begin
            // stage 0: accept boundary
            vld_p[0]   <= accept;
            rdata_p[0] <= ld_data;
            err_p[0]   <= accept && err;
            // stages 1..RD_LAT-1: delay line
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]   <= vld_p[i-1];
                rdata_p[i] <= rdata_p[i-1];
                err_p[i]   <= err_p[i-1];
            end
        end
    end

    assign rsp_valid = vld_p[RD_LAT-1];
    assign rsp_rdata = rdata_p[RD_LAT-1];
    assign rsp_err   = err_p[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe (DATA_W=32, DEPTH=16, RD_LAT=3).
module tb_dmem_pipe;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int AW    = 32;

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    dmem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic        b_we    [8];
    logic [1:0]  b_size  [8];
    logic        b_uns   [8];
    logic [31:0] b_addr  [8];
    logic [31:0] b_wdata [8];

    int          r_cyc  [8];
    logic [31:0] r_data [8];
    logic        r_err  [8];
    int          r_cnt;
    logic        rdy_log [32];

    task automatic set_op(input int i, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
        b_we[i]    = we;
        b_size[i]  = sz;
        b_uns[i]   = uns;
        b_addr[i]  = a;
        b_wdata[i] = wd;
    endtask

    // Issue n queued ops (each held until accepted) over a fixed 24-cycle window,
    // recording every consumed response and the cycle it was consumed in.
    task automatic burst(input int n, input logic [31:0] stall_mask);
        int   k;
        logic acc;
        k     = 0;
        r_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            r_cyc[i]  = -1;
            r_data[i] = 'x;
            r_err[i]  = 1'bx;
        end
        for (int c = 0; c < 24; c++) begin
            rsp_ready = !stall_mask[c];
            if (k < n) begin
                req_valid    = 1'b1;
                req_we       = b_we[k];
                req_size     = b_size[k];
                req_unsigned = b_uns[k];
                req_addr     = b_addr[k];
                req_wdata    = b_wdata[k];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            rdy_log[c] = req_ready;
            if (rsp_valid && rsp_ready) begin
                if (r_cnt < 8) begin
                    r_cyc[r_cnt]  = c;
                    r_data[r_cnt] = rsp_rdata;
                    r_err[r_cnt]  = rsp_err;
                end
                r_cnt++;
            end
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic single(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        set_op(0, we, sz, uns, a, wd);
        burst(1, 32'h0);
    endtask

    task automatic test_reset;
        int cnt;
        int exp_cnt;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            n_fails++;
            $display("FAIL reset_outputs: valid=%b err=%b rdata=%h, want 0 0 00000000", rsp_valid, rsp_err, rsp_rdata);
        end
`ifndef DMEM_RESET_CLEAR_EN
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end
        exp_cnt = 0;
`else
        exp_cnt = DEPTH;
`endif
        rstn = 1'b1;
        cnt  = 0;
        for (int n = 0; n < 4 * DEPTH; n++) begin
            if (req_ready === 1'b1) break;
            cnt++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (cnt != exp_cnt) begin
            n_fails++;
            $display("FAIL ready_low_cycles: got %0d, want %0d", cnt, exp_cnt);
        end
`ifdef DMEM_RESET_CLEAR_EN
        single(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'h0}) begin
            n_fails++;
            $display("FAIL clear_load: cnt=%0d err=%b data=%h, want 1 0 00000000", r_cnt, r_err[0], r_data[0]);
        end
`endif
    endtask

    task automatic test_load_extend;
        single(1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'h0}) begin
            n_fails++;
            $display("FAIL st_word_rsp: cnt=%0d err=%b data=%h, want 1 0 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'hFFFF_FF87}) begin
            n_fails++;
            $display("FAIL ld_byte_s: cnt=%0d err=%b data=%h, want 1 0 ffffff87", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'h0000_0065}) begin
            n_fails++;
            $display("FAIL ld_byte_u: cnt=%0d err=%b data=%h, want 1 0 00000065", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'h0000_8765}) begin
            n_fails++;
            $display("FAIL ld_half_u: cnt=%0d err=%b data=%h, want 1 0 00008765", r_cnt, r_err[0], r_data[0]);
        end
    endtask

    task automatic test_partial_store;
        single(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111);
        single(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF);
        single(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'hBEEF_1111}) begin
            n_fails++;
            $display("FAIL st_half_merge: cnt=%0d err=%b data=%h, want 1 0 beef1111", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'hFFFF_BEEF}) begin
            n_fails++;
            $display("FAIL ld_half_s: cnt=%0d err=%b data=%h, want 1 0 ffffbeef", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF5C);
        single(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'hBEEF_5C11}) begin
            n_fails++;
            $display("FAIL st_byte_merge: cnt=%0d err=%b data=%h, want 1 0 beef5c11", r_cnt, r_err[0], r_data[0]);
        end
    endtask

    task automatic test_errors;
        single(1'b1, 2'b10, 1'b0, 32'h04, 32'hA5A5_A5A5);
        single(1'b1, 2'b10, 1'b0, 32'h05, 32'hDEAD_BEEF);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_st_word_mis: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b1, 2'b01, 1'b0, 32'h07, 32'h0000_1234);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_st_half_mis: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_ld_half_mis: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_range: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b1, 2'b10, 1'b0, 32'(4 * DEPTH + 4), 32'h0BAD_0BAD);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_range_st: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL err_dword: cnt=%0d err=%b data=%h, want 1 1 00000000", r_cnt, r_err[0], r_data[0]);
        end
        single(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin
            n_fails++;
            $display("FAIL err_mem_kept: cnt=%0d err=%b data=%h, want 1 0 a5a5a5a5", r_cnt, r_err[0], r_data[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [4];
        vals[0] = 32'h1100_0001;
        vals[1] = 32'h2200_0002;
        vals[2] = 32'h3300_0003;
        vals[3] = 32'h4400_0004;
        for (int i = 0; i < 4; i++)
            set_op(i, 1'b1, 2'b10, 1'b0, 32'h30 + 32'(4 * i), vals[i]);
        burst(4, 32'h0);
        n_checks++;
        if (r_cnt != 4) begin
            n_fails++;
            $display("FAIL b2b_store_count: got %0d, want 4", r_cnt);
        end
        for (int i = 0; i < 4; i++)
            set_op(i, 1'b0, 2'b10, 1'b0, 32'h30 + 32'(4 * i), 32'h0);
        burst(4, 32'h0);
        n_checks++;
        if (r_cnt != 4) begin
            n_fails++;
            $display("FAIL b2b_load_count: got %0d, want 4", r_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_cyc[i] != i + LAT || {r_err[i], r_data[i]} !== {1'b0, vals[i]}) begin
                n_fails++;
                $display("FAIL b2b_load%0d: cyc=%0d err=%b data=%h, want cyc=%0d err=0 data=%h",
                         i, r_cyc[i], r_err[i], r_data[i], i + LAT, vals[i]);
            end
        end
        set_op(0, 1'b1, 2'b10, 1'b0, 32'h38, 32'hCAFE_0001);
        set_op(1, 1'b0, 2'b10, 1'b0, 32'h38, 32'h0);
        burst(2, 32'h0);
        n_checks++;
        if (r_cnt != 2 || r_cyc[1] != 1 + LAT || {r_err[1], r_data[1]} !== {1'b0, 32'hCAFE_0001}) begin
            n_fails++;
            $display("FAIL st_then_ld: cnt=%0d cyc=%0d err=%b data=%h, want cnt=2 cyc=%0d err=0 data=cafe0001",
                     r_cnt, r_cyc[1], r_err[1], r_data[1], 1 + LAT);
        end
    endtask

    task automatic test_stall;
        logic [31:0] vals [4];
        int          exp_cyc [4];
        vals[0] = 32'h1100_0001;
        vals[1] = 32'h2200_0002;
        vals[2] = 32'hCAFE_0001;
        vals[3] = 32'h4400_0004;
        exp_cyc[0] = 3;
        exp_cyc[1] = 6;
        exp_cyc[2] = 7;
        exp_cyc[3] = 8;
        for (int i = 0; i < 4; i++)
            set_op(i, 1'b0, 2'b10, 1'b0, 32'h30 + 32'(4 * i), 32'h0);
        burst(4, 32'h0000_0030);
        n_checks++;
        if ({rdy_log[3], rdy_log[4], rdy_log[5], rdy_log[6]} !== 4'b1001) begin
            n_fails++;
            $display("FAIL stall_ready: ready c3..c6=%b%b%b%b, want 1001",
                     rdy_log[3], rdy_log[4], rdy_log[5], rdy_log[6]);
        end
        n_checks++;
        if (r_cnt != 4) begin
            n_fails++;
            $display("FAIL stall_count: got %0d, want 4", r_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_cyc[i] != exp_cyc[i] || {r_err[i], r_data[i]} !== {1'b0, vals[i]}) begin
                n_fails++;
                $display("FAIL stall_rsp%0d: cyc=%0d err=%b data=%h, want cyc=%0d err=0 data=%h",
                         i, r_cyc[i], r_err[i], r_data[i], exp_cyc[i], vals[i]);
            end
        end
    endtask

    task automatic test_reset_inflight;
        int          stale;
        int          waited;
        logic [31:0] exp_data;
        single(1'b1, 2'b10, 1'b0, 32'h2C, 32'h5A5A_1234);
        rsp_ready    = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h2C;
        @(posedge clk);
        #1;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL inflight_before_reset: rsp_valid=%b, want 1", rsp_valid);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            n_fails++;
            $display("FAIL reset_flush: valid=%b err=%b rdata=%h, want 0 0 00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        rsp_ready = 1'b1;
        stale     = 0;
        for (int n = 0; n < 10; n++) begin
            if (rsp_valid === 1'b1) stale++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stale != 0) begin
            n_fails++;
            $display("FAIL stale_rsp: got %0d responses after reset, want 0", stale);
        end
        waited = 0;
        while (req_ready !== 1'b1 && waited < 4 * DEPTH) begin
            waited++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL ready_after_reset: req_ready=%b after %0d cycles, want 1", req_ready, waited);
        end
`ifdef DMEM_RESET_CLEAR_EN
        exp_data = 32'h0;
`else
        exp_data = 32'h5A5A_1234;
`endif
        single(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0);
        n_checks++;
        if ({r_cnt == 1, r_err[0], r_data[0]} !== {1'b1, 1'b0, exp_data}) begin
            n_fails++;
            $display("FAIL store_survives_reset: cnt=%0d err=%b data=%h, want 1 0 %h", r_cnt, r_err[0], r_data[0], exp_data);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        #1;
        test_reset;
        test_load_extend;
        test_partial_store;
        test_errors;
        test_back_to_back;
        test_stall;
        test_reset_inflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
